// File: rtl/encrypter_core.sv
// encrypter_core: iterative 64-bit substitution-permutation block cipher.
// Executes one round per clock. After ROUNDS rounds the whitened ciphertext
// and the final round key are registered and status is raised.
module encrypter_core #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    output logic        status,
    output logic [63:0] data_out,
    output logic [63:0] key_out
);

    localparam logic [7:0] ROUNDS_C = 8'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } fsm_t;

    fsm_t        fsm_r;
    logic [63:0] state_r;
    logic [63:0] key_r;
    logic [7:0]  cnt_r;

    logic [7:0]  rnd_s;
    logic [63:0] state_nxt_s;
    logic [63:0] key_nxt_s;

    // 4-bit substitution box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;
            4'h1: return 4'h5;
            4'h2: return 4'h6;
            4'h3: return 4'hB;
            4'h4: return 4'h9;
            4'h5: return 4'h0;
            4'h6: return 4'hA;
            4'h7: return 4'hD;
            4'h8: return 4'h3;
            4'h9: return 4'hE;
            4'hA: return 4'hF;
            4'hB: return 4'h8;
            4'hC: return 4'h4;
            4'hD: return 4'h7;
            4'hE: return 4'h1;
            default: return 4'h2;
        endcase
    endfunction

    // S-box applied to all 16 nibbles
    function automatic logic [63:0] sub_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4 * n) +: 4] = sbox(x[6'(4 * n) +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to (16*i) mod 63; bit 63 is fixed
    function automatic logic [63:0] perm_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            y[6'((16 * i) % 63)] = x[6'(i)];
        end
        return y;
    endfunction

    // Key schedule: rotate left 13, substitute top nibble, mix in round number
    function automatic logic [63:0] key_next(input logic [63:0] k, input logic [7:0] r);
        logic [63:0] t;
        t = {k[50:0], k[63:51]};
        t[63:60] = sbox(t[63:60]);
        t[7:0] = t[7:0] ^ r;
        return t;
    endfunction

    // Round number and next-round datapath; LOAD always starts with round 1
    always_comb begin
        rnd_s = 8'd0;
        if (fsm_r == LOAD) begin
            rnd_s = 8'd1;
        end else begin
            rnd_s = cnt_r + 8'd1;
        end
        state_nxt_s = perm_layer(sub_layer(state_r ^ key_r));
        key_nxt_s   = key_next(key_r, rnd_s);
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r    <= IDLE;
            state_r  <= 64'd0;
            key_r    <= 64'd0;
            cnt_r    <= 8'd0;
            status   <= 1'b0;
            data_out <= 64'd0;
            key_out  <= 64'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    status <= 1'b0;
                    if (set) begin
                        state_r <= data_in;
                        key_r   <= key_in;
                        cnt_r   <= 8'd0;
                        fsm_r   <= LOAD;
                    end else begin
                        fsm_r   <= IDLE;
                    end
                end
                LOAD: begin
                    status <= 1'b0;
                    if (set) begin
                        state_r <= data_in;
                        key_r   <= key_in;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= state_nxt_s;
                        key_r   <= key_nxt_s;
                        cnt_r   <= 8'd1;
                        fsm_r   <= RUN;
                    end
                end
                RUN: begin
                    if (set) begin
                        // abort: reload operands, previous result stays visible
                        state_r <= data_in;
                        key_r   <= key_in;
                        cnt_r   <= 8'd0;
                        status  <= 1'b0;
                        fsm_r   <= LOAD;
                    end else if (cnt_r == ROUNDS_C) begin
                        data_out <= state_r ^ key_r;
                        key_out  <= key_r;
                        status   <= 1'b1;
                        fsm_r    <= DONE;
                    end else begin
                        state_r <= state_nxt_s;
                        key_r   <= key_nxt_s;
                        cnt_r   <= rnd_s;
                    end
                end
                DONE: begin
                    if (set) begin
                        state_r <= data_in;
                        key_r   <= key_in;
                        cnt_r   <= 8'd0;
                        status  <= 1'b0;
                        fsm_r   <= LOAD;
                    end else begin
                        fsm_r   <= DONE;
                    end
                end
                default: begin
                    fsm_r  <= IDLE;
                    status <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypter_core.sv
// Self-checking bench for encrypter_core: a default 16-round instance and a
// 1-round instance share the inputs; results are compared to a reference model.
module tb_encrypter_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        set;
    logic [63:0] data_in;
    logic [63:0] key_in;
    logic        status16, status1;
    logic [63:0] dout16, kout16, dout1, kout1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    encrypter_core #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .set(set), .data_in(data_in), .key_in(key_in),
        .status(status16), .data_out(dout16), .key_out(kout16)
    );

    encrypter_core #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .set(set), .data_in(data_in), .key_in(key_in),
        .status(status1), .data_out(dout1), .key_out(kout1)
    );

    typedef struct {
        logic [63:0] d;
        logic [63:0] k;
        logic [63:0] exp16_c;
        logic [63:0] exp16_k;
        logic [63:0] exp1_c;
        logic [63:0] exp1_k;
    } vec_t;

    vec_t vecs[5];

    // Reference cipher computed straight from the algorithm description
    function automatic void model(input logic [63:0] d, input logic [63:0] k,
                                  input int rounds,
                                  output logic [63:0] c, output logic [63:0] ko);
        int lut[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
        logic [63:0] s, kk, t, u;
        int idx;
        s  = d;
        kk = k;
        for (int r = 1; r <= rounds; r++) begin
            t = s ^ kk;
            u = 64'd0;
            for (int n = 0; n < 16; n++) begin
                idx = int'((t >> (4 * n)) & 64'hF);
                u = u | (64'(lut[idx]) << (4 * n));
            end
            s = 64'd0;
            for (int i = 0; i < 64; i++) begin
                if (((u >> i) & 64'd1) != 64'd0) begin
                    if (i == 63) s = s | (64'd1 << 63);
                    else         s = s | (64'd1 << ((16 * i) % 63));
                end
            end
            kk  = (kk << 13) | (kk >> 51);
            idx = int'(kk >> 60);
            kk  = (kk & 64'h0FFF_FFFF_FFFF_FFFF) | (64'(lut[idx]) << 60);
            kk  = kk ^ 64'(r % 256);
        end
        c  = s ^ kk;
        ko = kk;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load operands, run to completion, check latency and both instances
    task automatic do_run(input logic [63:0] d, input logic [63:0] k,
                          input logic [63:0] e16c, input logic [63:0] e16k,
                          input logic [63:0] e1c, input logic [63:0] e1k);
        logic early;
        set = 1'b1; data_in = d; key_in = k;
        tick();
        chk("load_status", {63'd0, status16}, 64'd0);
        tick();
        set = 1'b0;
        early = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            tick();
            data_in = {$urandom, $urandom};
            key_in  = {$urandom, $urandom};
            if (e < 17 && status16) early = 1'b1;
            if (e == 2) begin
                chk("r1_status", {63'd0, status1}, 64'd1);
                chk("r1_data", dout1, e1c);
                chk("r1_key", kout1, e1k);
            end
        end
        chk("early_status", {63'd0, early}, 64'd0);
        chk("done_status", {63'd0, status16}, 64'd1);
        chk("done_data", dout16, e16c);
        chk("done_key", kout16, e16k);
    endtask

    initial begin
        logic [63:0] ec, ek, e1c, e1k, save_c, save_k, flip_c, flip_k;
        logic bad;

        // vector table: expected values from the model, plus a known-answer 1-round entry
        vecs[0].d = 64'd0;                 vecs[0].k = 64'd0;
        vecs[1].d = 64'hFFFF_FFFF_FFFF_FFFF; vecs[1].k = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 2; i < 5; i++) begin
            vecs[i].d = {$urandom, $urandom};
            vecs[i].k = {$urandom, $urandom};
        end
        for (int i = 0; i < 5; i++) begin
            model(vecs[i].d, vecs[i].k, 16, vecs[i].exp16_c, vecs[i].exp16_k);
            model(vecs[i].d, vecs[i].k, 1, vecs[i].exp1_c, vecs[i].exp1_k);
        end
        vecs[0].exp1_c = 64'h3FFF_FFFF_0000_0001;
        vecs[0].exp1_k = 64'hC000_0000_0000_0001;

        // reset state
        rst = 1'b1; set = 1'b0; data_in = 64'd0; key_in = 64'd0;
        tick(); tick();
        chk("rst_status", {63'd0, status16}, 64'd0);
        chk("rst_data", dout16, 64'd0);
        chk("rst_key", kout16, 64'd0);
        rst = 1'b0;
        tick();

        // table-driven runs, each followed by a 20-cycle hold with toggling inputs
        for (int i = 0; i < 5; i++) begin
            do_run(vecs[i].d, vecs[i].k, vecs[i].exp16_c, vecs[i].exp16_k,
                   vecs[i].exp1_c, vecs[i].exp1_k);
            bad = 1'b0;
            for (int c = 0; c < 20; c++) begin
                data_in = {$urandom, $urandom};
                key_in  = {$urandom, $urandom};
                tick();
                if (!status16 || dout16 !== vecs[i].exp16_c || kout16 !== vecs[i].exp16_k)
                    bad = 1'b1;
            end
            chk("hold_done", {63'd0, bad}, 64'd0);
        end

        // abort: raise set at edge 5 of a run, then restart with same operands
        save_c = dout16; save_k = kout16;
        set = 1'b1; data_in = vecs[2].d; key_in = vecs[2].k;
        tick(); tick();
        set = 1'b0;
        bad = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            data_in = {$urandom, $urandom};
            if (status16 || dout16 !== save_c || kout16 !== save_k) bad = 1'b1;
        end
        set = 1'b1; data_in = vecs[2].d; key_in = vecs[2].k;
        tick();
        if (status16 || dout16 !== save_c || kout16 !== save_k) bad = 1'b1;
        chk("abort_quiet", {63'd0, bad}, 64'd0);
        do_run(vecs[2].d, vecs[2].k, vecs[2].exp16_c, vecs[2].exp16_k,
               vecs[2].exp1_c, vecs[2].exp1_k);

        // back-to-back: identical rerun, then rerun with data bit 0 flipped
        save_c = dout16; save_k = kout16;
        do_run(vecs[2].d, vecs[2].k, vecs[2].exp16_c, vecs[2].exp16_k,
               vecs[2].exp1_c, vecs[2].exp1_k);
        chk("rerun_data", dout16, save_c);
        chk("rerun_key", kout16, save_k);
        model(vecs[2].d ^ 64'd1, vecs[2].k, 16, flip_c, flip_k);
        model(vecs[2].d ^ 64'd1, vecs[2].k, 1, e1c, e1k);
        do_run(vecs[2].d ^ 64'd1, vecs[2].k, flip_c, flip_k, e1c, e1k);
        tests++;
        if (dout16 === save_c) begin
            fails++;
            $display("FAIL flip_differs: got %h expected value different from %h", dout16, save_c);
        end
        chk("flip_key", kout16, save_k);

        // hold with set=1 for 100 cycles
        save_c = dout16; save_k = kout16;
        set = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            data_in = {$urandom, $urandom};
            key_in  = {$urandom, $urandom};
            tick();
            if (status16 || dout16 !== save_c || kout16 !== save_k) bad = 1'b1;
        end
        chk("set_hold", {63'd0, bad}, 64'd0);

        // async reset mid-run, checked without a clock edge
        set = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_status", {63'd0, status16}, 64'd0);
        chk("arst_data", dout16, 64'd0);
        chk("arst_key", kout16, 64'd0);
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 50; c++) begin
            data_in = {$urandom, $urandom};
            tick();
            if (status16 || status1 || dout16 !== 64'd0 || dout1 !== 64'd0) bad = 1'b1;
        end
        chk("idle_no_run", {63'd0, bad}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
